arb_lock_ctrl: RTL and testbench

Root-side ownership controller for the binary arbitration tree of 2-input round-robin cells. Samples the tree root's request and drives the root's downward grant for exactly one cycle per arbitration. In that cycle it captures the one-hot leaf grant vector and latches the winner as resource owner. Holds ownership, with the tree idle, until the owner releases, drops its request, or exceeds a hold limit.

---
 rtl/arb_lock_ctrl.sv | 132 +++++++++++++
 tb/tb_arb_lock_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_lock_ctrl.sv
// Root-side ownership controller for a binary round-robin arbitration tree.
// Grants the tree root once per arbitration and latches the winner as owner.
module arb_lock_ctrl #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             root_req,
   output logic             root_gnt,
   input  logic [N-1:0]     leaf_gnt,
   input  logic [N-1:0]     req_in,
   input  logic [N-1:0]     release_strb,
   output logic [N-1:0]     gnt_out,
   output logic [IDX_W-1:0] owner_idx,
   output logic             owner_valid,
   output logic             timeout_evt,
   output logic             arb_err
);

   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [N-1:0] LSB = N'(1);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_LAST =
      (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic HOLD_ON = (MAX_HOLD > 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      OWN  = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     gnt_d;
   logic [IDX_W-1:0] idx_d;
   logic             valid_d;
   logic             tout_d;
   logic             err_d;

   logic             leaf_any;
   logic             leaf_multi;
   logic [IDX_W-1:0] leaf_idx;
   logic             owner_rel;
   logic             owner_req;
   logic             owner_drop;
   logic             hold_hit;

   assign leaf_any   = |leaf_gnt;
   assign leaf_multi = |(leaf_gnt & (leaf_gnt - LSB));

   // OR-encode is exact only for one-hot input, which is all we latch.
   always_comb begin
      leaf_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (leaf_gnt[i]) leaf_idx = leaf_idx | IDX_W'(i);
      end
   end

   assign owner_rel  = release_strb[owner_idx];
   assign owner_req  = req_in[owner_idx];
   assign owner_drop = owner_rel | ~owner_req;
   assign hold_hit   = HOLD_ON & (cnt_q == CNT_LAST);

   assign root_gnt = (state_q == ARB);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_out;
      idx_d   = owner_idx;
      valid_d = owner_valid;
      tout_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (root_req) state_d = ARB;
         end
         ARB: begin
            if (leaf_any && !leaf_multi) begin
               gnt_d   = leaf_gnt;
               idx_d   = leaf_idx;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = OWN;
            end else begin
               err_d   = leaf_multi;
               state_d = IDLE;
            end
         end
         OWN: begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            // A voluntary exit suppresses the timeout pulse.
            if (owner_drop || hold_hit) begin
               tout_d  = ~owner_drop;
               gnt_d   = '0;
               valid_d = 1'b0;
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = root_req ? ARB : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_out     <= '0;
         owner_idx   <= '0;
         owner_valid <= 1'b0;
         timeout_evt <= 1'b0;
         arb_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_out     <= gnt_d;
         owner_idx   <= idx_d;
         owner_valid <= valid_d;
         timeout_evt <= tout_d;
         arb_err     <= err_d;
      end
   end

endmodule

// File: tb/tb_arb_lock_ctrl.sv
// Bench for arb_lock_ctrl: stub round-robin tree, directed and random
// stimulus, outputs compared each cycle against an ownership model.
module tb_arb_lock_ctrl;

   localparam int N  = 4;
   localparam int MH = 8;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          root_req;
   logic          root_gnt;
   logic [N-1:0]  leaf_gnt;
   logic [N-1:0]  req_in;
   logic [N-1:0]  release_strb;
   logic [N-1:0]  gnt_out;
   logic [IW-1:0] owner_idx;
   logic          owner_valid;
   logic          timeout_evt;
   logic          arb_err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   arb_lock_ctrl #(.N(N), .MAX_HOLD(MH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .root_req     (root_req),
      .root_gnt     (root_gnt),
      .leaf_gnt     (leaf_gnt),
      .req_in       (req_in),
      .release_strb (release_strb),
      .gnt_out      (gnt_out),
      .owner_idx    (owner_idx),
      .owner_valid  (owner_valid),
      .timeout_evt  (timeout_evt),
      .arb_err      (arb_err)
   );

   // Stub tree: flat round-robin pick, or a forced leaf pattern.
   logic         force_mode = 1'b0;
   logic         force_req  = 1'b0;
   logic [N-1:0] force_val  = '0;
   logic [N-1:0] stub_val;
   int           rr_ptr = N - 1;

   function automatic logic [N-1:0] rr_pick(logic [N-1:0] r, int ptr);
      logic [N-1:0] one;
      one = 1;
      for (int i = 1; i <= N; i++) begin
         automatic int k = (ptr + i) % N;
         if (r[k]) return one << k;
      end
      return '0;
   endfunction

   always_comb stub_val = force_mode ? force_val : rr_pick(req_in, rr_ptr);
   assign leaf_gnt = root_gnt ? stub_val : '0;
   assign root_req = force_mode ? force_req : |req_in;

   always @(posedge clk) begin
      if (root_gnt && !force_mode)
         for (int i = 0; i < N; i++)
            if (stub_val[i]) rr_ptr <= i;
   end

   // Model: who owns, how long they have held, and whether this
   // cycle is the single arbitration cycle.
   int m_owner;
   int m_held;
   int m_last;
   bit m_arb;
   bit m_tout;
   bit m_err;

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_last  = 0;
      m_arb   = 0;
      m_tout  = 0;
      m_err   = 0;
   endtask

   task automatic model_step();
      bit arb_n  = 0;
      bit tout_n = 0;
      bit err_n  = 0;
      if (m_arb) begin
         if ($countones(stub_val) == 1) begin
            for (int i = 0; i < N; i++)
               if (stub_val[i]) m_owner = i;
            m_last = m_owner;
            m_held = 1;
         end else if ($countones(stub_val) > 1) begin
            err_n = 1;
         end
      end else if (m_owner >= 0) begin
         automatic bit dropped =
            release_strb[m_owner] || !req_in[m_owner];
         if (dropped || m_held == MH) begin
            tout_n  = !dropped;
            m_owner = -1;
         end else begin
            m_held++;
         end
      end else begin
         arb_n = root_req;
      end
      m_arb  = arb_n;
      m_tout = tout_n;
      m_err  = err_n;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      chk("root_gnt", 32'(root_gnt), 32'(m_arb));
      chk("gnt_out", 32'(gnt_out), 32'(g));
      chk("owner_valid", 32'(owner_valid), 32'(m_owner >= 0));
      chk("owner_idx", 32'(owner_idx), 32'(m_last));
      chk("timeout_evt", 32'(timeout_evt), 32'(m_tout));
      chk("arb_err", 32'(arb_err), 32'(m_err));
   endtask

   task automatic cycle(logic [N-1:0] req, logic [N-1:0] rel);
      req_in       = req;
      release_strb = rel;
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] owner_rel_after(int n);
      logic [N-1:0] r;
      r = '0;
      if (m_owner >= 0 && m_held >= n) r[m_owner] = 1'b1;
      return r;
   endfunction

   initial begin
      rst_n        = 1'b0;
      req_in       = '0;
      release_strb = '0;
      model_reset();
      @(negedge clk);
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single client, release after a few owned cycles.
      repeat (6) cycle(4'b0100, 4'b0000);
      cycle(4'b0100, 4'b0100);
      repeat (3) cycle(4'b0000, 4'b0000);

      // Two clients alternating, owner releases after 2 cycles.
      repeat (20) cycle(4'b0011, owner_rel_after(2));
      repeat (3) cycle(4'b0000, 4'b0000);

      // Hold limit: no release, forced revoke, regrant.
      repeat (24) cycle(4'b1000, 4'b0000);
      repeat (3) cycle(4'b0000, 4'b0000);

      // Non-owner release ignored, then request drop.
      repeat (3) cycle(4'b0010, 4'b0000);
      repeat (2) cycle(4'b0010, 4'b0100);
      repeat (3) cycle(4'b0000, 4'b0000);

      // Forced leaf patterns during ARB.
      force_mode = 1'b1;
      force_req  = 1'b1;
      force_val  = 4'b0000;
      cycle(4'b0000, 4'b0000);
      force_req = 1'b0;
      repeat (3) cycle(4'b0000, 4'b0000);
      force_req = 1'b1;
      force_val = 4'b0110;
      cycle(4'b0000, 4'b0000);
      force_req = 1'b0;
      repeat (3) cycle(4'b0000, 4'b0000);
      force_mode = 1'b0;

      // Asynchronous reset in the middle of ownership.
      repeat (4) cycle(4'b0001, 4'b0000);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_gnt_out", 32'(gnt_out), 32'h0);
      chk("rst_owner_valid", 32'(owner_valid), 32'h0);
      chk("rst_root_gnt", 32'(root_gnt), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) cycle(4'b0001, 4'b0000);
      repeat (2) cycle(4'b0000, 4'b0000);

      // Random traffic, including non-owner release strobes.
      begin
         logic [N-1:0] rq;
         logic [N-1:0] rl;
         rq = '0;
         for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) rq = N'($urandom_range(0, 15));
            rl = ($urandom_range(0, 3) == 0) ?
                 N'($urandom_range(0, 15)) : '0;
            cycle(rq, rl);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
